// File: rtl/ofdm_symbol_scheduler_if.sv
// Stream/control bundle for the OFDM symbol scheduler.
// The slave modport is the scheduler's view; the master modport is the sample source / FFT side.
interface ofdm_symbol_scheduler_if #(
  parameter int DW      = 32,
  parameter int FFT_LEN = 64,
  parameter int SYM_NUM = 8
);
  localparam int IW = $clog2(FFT_LEN);
  localparam int SW = $clog2(SYM_NUM);

  logic          frame_start;
  logic [SW-1:0] sym_num_m1;
  logic          abort;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          dout_valid;
  logic [DW-1:0] dout;
  logic [IW-1:0] dout_idx;
  logic [SW-1:0] sym_idx;
  logic          sop;
  logic          eop;
  logic          frame_done;
  logic          busy;

  modport slave (
    input  frame_start, sym_num_m1, abort, din_valid, din,
    output dout_valid, dout, dout_idx, sym_idx, sop, eop, frame_done, busy
  );

  modport master (
    output frame_start, sym_num_m1, abort, din_valid, din,
    input  dout_valid, dout, dout_idx, sym_idx, sop, eop, frame_done, busy
  );
endinterface

// File: rtl/ofdm_symbol_scheduler.sv
// RX-side OFDM symbol sequencer: per symbol, drops CP_LEN cyclic-prefix samples and
// forwards FFT_LEN samples tagged with sample index, symbol index and SOP/EOP.
module ofdm_symbol_scheduler #(
  parameter int DW      = 32,
  parameter int FFT_LEN = 64,
  parameter int CP_LEN  = 16,
  parameter int SYM_NUM = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ofdm_symbol_scheduler_if.slave bus
);
  localparam int IW = $clog2(FFT_LEN);
  localparam int SW = $clog2(SYM_NUM);
  localparam int CW = (CP_LEN > 1) ? $clog2(CP_LEN) : 1;
  localparam logic [CW-1:0] CP_LAST  = CW'(CP_LEN - 1);
  localparam logic [IW-1:0] FFT_LAST = IW'(FFT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t        r_state,   w_state_nxt;
  logic [CW-1:0] r_cp_cnt,  w_cp_cnt_nxt;
  logic [IW-1:0] r_data_cnt, w_data_cnt_nxt;
  logic [SW-1:0] r_sym_cnt, w_sym_cnt_nxt;
  logic [SW-1:0] r_sym_last, w_sym_last_nxt;
  logic          r_dout_valid, w_dout_valid_nxt;
  logic [DW-1:0] r_dout,    w_dout_nxt;
  logic [IW-1:0] r_dout_idx, w_dout_idx_nxt;
  logic [SW-1:0] r_sym_idx, w_sym_idx_nxt;
  logic          r_sop,     w_sop_nxt;
  logic          r_eop,     w_eop_nxt;
  logic          r_frame_done, w_frame_done_nxt;

  // Next-state, counter and output computation; abort overrides everything else.
  always_comb begin
    w_state_nxt      = r_state;
    w_cp_cnt_nxt     = r_cp_cnt;
    w_data_cnt_nxt   = r_data_cnt;
    w_sym_cnt_nxt    = r_sym_cnt;
    w_sym_last_nxt   = r_sym_last;
    w_dout_valid_nxt = 1'b0;
    w_dout_nxt       = r_dout;
    w_dout_idx_nxt   = r_dout_idx;
    w_sym_idx_nxt    = r_sym_idx;
    w_sop_nxt        = 1'b0;
    w_eop_nxt        = 1'b0;
    w_frame_done_nxt = 1'b0;

    if (bus.abort) begin
      w_state_nxt    = ST_IDLE;
      w_cp_cnt_nxt   = '0;
      w_data_cnt_nxt = '0;
      w_sym_cnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.frame_start) begin
            w_sym_last_nxt = bus.sym_num_m1;
            w_cp_cnt_nxt   = '0;
            w_data_cnt_nxt = '0;
            w_sym_cnt_nxt  = '0;
            w_state_nxt    = ST_CP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_CP: begin
          if (bus.din_valid) begin
            if (r_cp_cnt == CP_LAST) begin
              w_cp_cnt_nxt = '0;
              w_state_nxt  = ST_DATA;
            end else begin
              w_cp_cnt_nxt = r_cp_cnt + CW'(1);
            end
          end else begin
            w_state_nxt = ST_CP;
          end
        end
        ST_DATA: begin
          if (bus.din_valid) begin
            w_dout_valid_nxt = 1'b1;
            w_dout_nxt       = bus.din;
            w_dout_idx_nxt   = r_data_cnt;
            w_sym_idx_nxt    = r_sym_cnt;
            w_sop_nxt        = (r_data_cnt == '0);
            w_eop_nxt        = (r_data_cnt == FFT_LAST);
            if (r_data_cnt == FFT_LAST) begin
              w_data_cnt_nxt = '0;
              if (r_sym_cnt == r_sym_last) begin
                w_frame_done_nxt = 1'b1;
                w_state_nxt      = ST_IDLE;
              end else begin
                w_sym_cnt_nxt = r_sym_cnt + SW'(1);
                w_state_nxt   = ST_CP;
              end
            end else begin
              w_data_cnt_nxt = r_data_cnt + IW'(1);
            end
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_cp_cnt_nxt   = '0;
          w_data_cnt_nxt = '0;
          w_sym_cnt_nxt  = '0;
        end
      endcase
    end
  end

  // State, counter and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cp_cnt     <= '0;
      r_data_cnt   <= '0;
      r_sym_cnt    <= '0;
      r_sym_last   <= '0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_dout_idx   <= '0;
      r_sym_idx    <= '0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cp_cnt     <= w_cp_cnt_nxt;
      r_data_cnt   <= w_data_cnt_nxt;
      r_sym_cnt    <= w_sym_cnt_nxt;
      r_sym_last   <= w_sym_last_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_idx   <= w_dout_idx_nxt;
      r_sym_idx    <= w_sym_idx_nxt;
      r_sop        <= w_sop_nxt;
      r_eop        <= w_eop_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.dout_valid = r_dout_valid;
  assign bus.dout       = r_dout;
  assign bus.dout_idx   = r_dout_idx;
  assign bus.sym_idx    = r_sym_idx;
  assign bus.sop        = r_sop;
  assign bus.eop        = r_eop;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Self-checking bench for ofdm_symbol_scheduler with a position-arithmetic reference model.
module tb_ofdm_symbol_scheduler;
  localparam int DW      = 16;
  localparam int FFT_LEN = 8;
  localparam int CP_LEN  = 2;
  localparam int SYM_NUM = 4;
  localparam int SW      = $clog2(SYM_NUM);
  localparam int L       = CP_LEN + FFT_LEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofdm_symbol_scheduler_if #(.DW(DW), .FFT_LEN(FFT_LEN), .SYM_NUM(SYM_NUM)) u_if ();

  ofdm_symbol_scheduler #(.DW(DW), .FFT_LEN(FFT_LEN), .CP_LEN(CP_LEN), .SYM_NUM(SYM_NUM)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: count valid samples since frame start and derive everything arithmetically.
  bit            m_active = 1'b0;
  int            m_pos    = 0;
  int            m_nsym   = 0;
  logic          e_dv, e_sop, e_eop, e_fd;
  logic [DW-1:0] e_dout = '0;
  int            e_idx, e_sym;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    chk("dout_valid", 32'(u_if.dout_valid), 32'(e_dv));
    chk("dout",       32'(u_if.dout),       32'(e_dout));
    chk("sop",        32'(u_if.sop),        32'(e_sop));
    chk("eop",        32'(u_if.eop),        32'(e_eop));
    chk("frame_done", 32'(u_if.frame_done), 32'(e_fd));
    chk("busy",       32'(u_if.busy),       32'(m_active));
    if (e_dv) begin
      chk("dout_idx", 32'(u_if.dout_idx), 32'(e_idx));
      chk("sym_idx",  32'(u_if.sym_idx),  32'(e_sym));
    end
  endtask

  task automatic step(input logic fs, input logic [SW-1:0] snm, input logic ab,
                      input logic dv, input logic [DW-1:0] d);
    int off, s;
    u_if.frame_start = fs;
    u_if.sym_num_m1  = snm;
    u_if.abort       = ab;
    u_if.din_valid   = dv;
    u_if.din         = d;
    e_dv = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_fd = 1'b0;
    if (ab) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (fs) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_nsym   = int'(snm) + 1;
      end
    end else if (dv) begin
      off = m_pos % L;
      s   = m_pos / L;
      if (off >= CP_LEN) begin
        e_dv   = 1'b1;
        e_dout = d;
        e_idx  = off - CP_LEN;
        e_sym  = s;
        e_sop  = (e_idx == 0);
        e_eop  = (e_idx == FFT_LEN - 1);
        e_fd   = e_eop && (s == m_nsym - 1);
      end
      m_pos++;
      if (m_pos == m_nsym * L) m_active = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    e_dv = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_fd = 1'b0;
    e_dout = '0; e_idx = 0; e_sym = 0;
  endtask

  initial begin
    logic [SW-1:0] snm;
    u_if.frame_start = 1'b0;
    u_if.sym_num_m1  = '0;
    u_if.abort       = 1'b0;
    u_if.din_valid   = 1'b0;
    u_if.din         = '0;
    model_reset();
    #12;
    check_outputs();
    chk("rst_dout_idx", 32'(u_if.dout_idx), 32'd0);
    chk("rst_sym_idx",  32'(u_if.sym_idx),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: two symbols, continuous ramp 0..19; din_valid in the frame_start cycle is ignored.
    step(1'b1, SW'(1), 1'b0, 1'b1, 16'hDEAD);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b1, DW'(i));
    step(1'b0, '0, 1'b0, 1'b0, 16'h0);

    // 2: same frame with din_valid alternating.
    step(1'b1, SW'(1), 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, DW'(i));
      step(1'b0, '0, 1'b0, 1'b0, DW'($urandom));
    end

    // 3: single symbol, then an 11th sample that must not be forwarded.
    step(1'b1, SW'(0), 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b0, 1'b1, DW'($urandom));

    // 4: abort after the 5th data sample of symbol 0, then restart.
    step(1'b1, SW'(2), 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < CP_LEN + 5; i++) step(1'b0, '0, 1'b0, 1'b1, DW'($urandom));
    step(1'b0, '0, 1'b1, 1'b1, DW'($urandom));
    step(1'b0, '0, 1'b0, 1'b1, DW'($urandom));
    step(1'b1, SW'(0), 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < L; i++) step(1'b0, '0, 1'b0, 1'b1, DW'($urandom));

    // 5: frame_start mid-frame is ignored; back-to-back frame_start after frame_done is accepted.
    step(1'b1, SW'(1), 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 2 * L; i++)
      step((i == 5) || (i == 13), SW'(3), 1'b0, 1'b1, DW'($urandom));
    step(1'b1, SW'(0), 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < L; i++) step(1'b0, '0, 1'b0, 1'b1, DW'($urandom));

    // Randomized frames with gaps and an occasional abort.
    for (int f = 0; f < 6; f++) begin
      snm = SW'($urandom_range(0, SYM_NUM - 1));
      step(1'b1, snm, 1'b0, 1'($urandom), DW'($urandom));
      for (int i = 0; i < 400 && m_active; i++)
        step(1'($urandom_range(0, 7) == 0), SW'($urandom), (f == 3) && ($urandom_range(0, 30) == 0),
             ($urandom_range(0, 3) != 0), DW'($urandom));
      chk("rand_frame_end", 32'(u_if.busy), 32'd0);
      step(1'b0, '0, 1'b0, 1'b1, DW'($urandom));
    end

    // 6: asynchronous reset during DATA, then valid input without frame_start.
    step(1'b1, SW'(1), 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < CP_LEN + 3; i++) step(1'b0, '0, 1'b0, 1'b1, DW'(16'h1234 + i));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("arst_dout_idx", 32'(u_if.dout_idx), 32'd0);
    chk("arst_sym_idx",  32'(u_if.sym_idx),  32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b1, DW'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
